// File: rtl/instruction_encoder.sv
// Encodes decoded instruction fields into MIPS words with byte addresses for the instruction memory.
// Optional sticky illegal-kind flag enabled by defining ENC_ERR_EN.
module instruction_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm16,
  input  logic [25:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        full,
  output logic        err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_EMPTY,
    ST_FULL_REG
  } state_e;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_SLT  = 4'd2,
    K_JR   = 4'd3,
    K_ADDI = 4'd4,
    K_LW   = 4'd5,
    K_SW   = 4'd6,
    K_BNE  = 4'd7,
    K_J    = 4'd8,
    K_JAL  = 4'd9
  } kind_e;

  state_e        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;

  logic [31:0]   enc_word;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_inc;
  logic          in_xfer;
  logic          out_xfer;

  always_comb begin
    enc_word = '0;
    case (kind)
      K_ADD:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      K_SUB:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      K_SLT:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      K_JR:   enc_word = {6'b000000, rs, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
      K_ADDI: enc_word = {6'b001000, rs, rt, imm16};
      K_LW:   enc_word = {6'b100011, rs, rt, imm16};
      K_SW:   enc_word = {6'b101011, rs, rt, imm16};
      K_BNE:  enc_word = {6'b000101, rs, rt, imm16};
      K_J:    enc_word = {6'b000010, target};
      K_JAL:  enc_word = {6'b000011, target};
      default: enc_word = '0;
    endcase
  end

  assign out_valid = (state_q == ST_FULL_REG);
  assign in_ready  = !full_q && (state_q == ST_EMPTY || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // start clears the counter before a same-cycle accepted bundle takes its address
  assign cnt_base = start ? '0 : count_q;
  assign cnt_inc  = cnt_base + CW'(1);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = cnt_base;
    full_d  = start ? 1'b0 : full_q;
    if (in_xfer) begin
      state_d = ST_FULL_REG;
      word_d  = enc_word;
      addr_d  = BASE_ADDR + (32'(cnt_base) << 2);
      count_d = cnt_inc;
      if (cnt_inc == CW'(DEPTH)) begin
        full_d = 1'b1;
      end
    end else if (out_xfer) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      word_q  <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign out_word = word_q;
  assign out_addr = addr_q;
  assign full     = full_q;

`ifdef ENC_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = start ? 1'b0 : err_q;
    if (in_xfer && kind > 4'd9) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench for instruction_encoder (BASE_ADDR=0x1000, DEPTH=4).
module tb_instruction_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, out_valid, out_ready, full, err;
  logic [3:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] out_word, out_addr;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

`ifdef ENC_ERR_EN
  localparam logic [31:0] ERR_EXP = 32'd1;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  typedef struct packed {
    logic [3:0]  k;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  instruction_encoder #(.BASE_ADDR(BASE), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
    kind = k; rs = s; rt = t; rd = d; imm16 = im; target = tg;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{k: 4'd1, rs: 5'd1,  rt: 5'd2,  rd: 5'd3,  imm: 16'hFFFF, tgt: 26'h3FFFFFF, exp: 32'h0022_1822};
    vecs[1] = '{k: 4'd2, rs: 5'd8,  rt: 5'd9,  rd: 5'd10, imm: 16'hFFFF, tgt: 26'h3FFFFFF, exp: 32'h0109_502A};
    vecs[2] = '{k: 4'd3, rs: 5'd31, rt: 5'd5,  rd: 5'd6,  imm: 16'hFFFF, tgt: 26'h3FFFFFF, exp: 32'h03E0_0008};
    vecs[3] = '{k: 4'd7, rs: 5'd3,  rt: 5'd4,  rd: 5'd31, imm: 16'hFFFE, tgt: 26'h3FFFFFF, exp: 32'h1464_FFFE};
    vecs[4] = '{k: 4'd9, rs: 5'd31, rt: 5'd31, rd: 5'd31, imm: 16'hFFFF, tgt: 26'h1234567, exp: 32'h0D23_4567};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(4'd0, '0, '0, '0, '0, '0);
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", out_word, 32'h0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // ADD rs=31 rt=0 rd=17, unused fields all ones
    drive(4'd0, 5'd31, 5'd0, 5'd17, 16'hFFFF, 26'h3FFFFFF);
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check("add_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_word", out_word, 32'h03E0_8820);
    check("add_addr", out_addr, BASE);
    step();
    check("add_drain", 32'(out_valid), 32'd0);
    pulse_start();

    // back-to-back ADDI then J, no bubble
    drive(4'd4, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h3FFFFFF);
    in_valid = 1'b1;
    step();
    check("addi_word", out_word, 32'h2022_FFFF);
    check("addi_addr", out_addr, BASE);
    drive(4'd8, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010);
    #1 check("b2b_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("j_valid", 32'(out_valid), 32'd1);
    check("j_word", out_word, 32'h0800_0010);
    check("j_addr", out_addr, BASE + 32'd4);
    step();
    pulse_start();

    // stall: LW held for 3 cycles while SW waits
    drive(4'd5, 5'd4, 5'd5, 5'd0, 16'h0008, 26'h0);
    in_valid = 1'b1;
    step();
    drive(4'd6, 5'd29, 5'd31, 5'd0, 16'h0004, 26'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_in_ready", 32'(in_ready), 32'd0);
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_word", out_word, 32'h8C85_0008);
      check("stall_addr", out_addr, BASE);
    end
    out_ready = 1'b1;
    #1 check("unstall_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("sw_word", out_word, 32'hAFBF_0004);
    check("sw_addr", out_addr, BASE + 32'd4);
    step();
    pulse_start();

    // stream 4 bundles to reach DEPTH, 5th must be held until start
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].k, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt);
      in_valid = 1'b1;
      #1 check("strm_in_ready", 32'(in_ready), 32'd1);
      check("strm_full_pre", 32'(full), 32'd0);
      step();
      check("strm_word", out_word, vecs[i].exp);
      check("strm_addr", out_addr, BASE + 32'(4 * i));
    end
    check("full_set", 32'(full), 32'd1);
    drive(vecs[4].k, vecs[4].rs, vecs[4].rt, vecs[4].rd, vecs[4].imm, vecs[4].tgt);
    #1 check("full_in_ready", 32'(in_ready), 32'd0);
    step();
    check("full_held", 32'(full), 32'd1);
    check("full_drained", 32'(out_valid), 32'd0);
    check("full_in_ready2", 32'(in_ready), 32'd0);
    pulse_start();
    check("start_full_clr", 32'(full), 32'd0);
    #1 check("start_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("jal_word", out_word, vecs[4].exp);
    check("jal_addr", out_addr, BASE);
    step();
    pulse_start();

    // illegal kind
    drive(4'd12, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ill_valid", 32'(out_valid), 32'd1);
    check("ill_word", out_word, 32'h0);
    check("ill_addr", out_addr, BASE);
    check("ill_err", 32'(err), ERR_EXP);
    step();
    check("ill_err_sticky", 32'(err), ERR_EXP);

    // start keeps an in-flight word and its address
    drive(4'd2, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("slt_word", out_word, 32'h0109_502A);
    check("slt_addr", out_addr, BASE + 32'd4);
    pulse_start();
    check("keep_valid", 32'(out_valid), 32'd1);
    check("keep_word", out_word, 32'h0109_502A);
    check("keep_addr", out_addr, BASE + 32'd4);
    check("start_err_clr", 32'(err), 32'd0);

    // reset mid-stream discards the pending word
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_word", out_word, 32'h0);
    check("mrst_addr", out_addr, BASE);
    check("mrst_full", 32'(full), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    drive(4'd0, 5'd31, 5'd0, 5'd17, 16'h0, 26'h0);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_rst_word", out_word, 32'h03E0_8820);
    check("post_rst_addr", out_addr, BASE);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

- Converts decoded instruction fields (kind, registers, immediate, jump target) into 32-bit MIPS-format instruction words and streams them, with word addresses, into the CPU's instruction memory.
- Inverse of the core's instruction decoder; testbenches and the program loader use it to build programs in hardware rather than hand-writing binary constants.
- Single-stage registered pipeline with valid/ready on both sides, plus a program address counter with a capacity limit.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of first emitted word
- DEPTH, 256, maximum number of words per program (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  restart program: clear address counter and full
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle
- kind  in  4  0 ADD, 1 SUB, 2 SLT, 3 JR, 4 ADDI, 5 LW, 6 SW, 7 BNE, 8 J, 9 JAL; 10–15 illegal
- rs, rt, rd  in  5 each  register fields
- imm16  in  16  I-type immediate / branch offset
- target  in  26  J-type word target
- out_valid  out  1  encoded word valid
- out_ready  in  1  memory accepts word
- out_word  out  32  encoded instruction
- out_addr  out  32  byte address of out_word
- full  out  1  DEPTH words emitted since start/reset
- err  out  1  sticky illegal-kind flag (ENC_ERR_EN only; tied 0 otherwise)

## Operation
- Encoding, opcode[31:26]:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}; funct ADD 100000, SUB 100010, SLT 101010, JR 001000 (JR forces rt=rd=0).
  - I-type: {op, rs, rt, imm16}; ADDI 001000, LW 100011, SW 101011, BNE 000101.
  - J-type: {op, target}; J 000010, JAL 000011.
- Unused input fields are ignored, never OR'd into the word.
- States:
  - EMPTY: out_valid=0.
  - FULL_REG: out_valid=1, holding a word.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- in_ready = !full_cnt_reached & (EMPTY | out_ready). A simultaneous output and input transfer in the same cycle reloads the register with no bubble.
- Address counter: out_addr = BASE_ADDR + 4·count; count is loaded into the register alongside the word at input transfer and increments on each input transfer.
- full asserts in the cycle after the DEPTH-th input transfer and stays high until start or reset. A pending word still drains while full.
- start has priority over in_valid in the same cycle:
  - count←0, full←0, err←0.
  - An in-flight output word is kept and keeps its original address.
- Arithmetic: count is clog2(DEPTH+1) bits. Address arithmetic wraps modulo 2^32 and is not range-checked.

## Timing
- Latency: input transfer in cycle N → out_valid, out_word, out_addr valid in cycle N+1.
- Throughput: 1 word/cycle while out_ready=1.
- out_word and out_addr are stable while out_valid=1 and out_ready=0.
- Reset, including mid-stream:
  - in_ready=1, out_valid=0, out_word=0, out_addr=BASE_ADDR, full=0, err=0, count=0, state EMPTY.
  - A pending word is discarded.
- All outputs are registered except in_ready, which is combinational from state, full and out_ready.

## Configuration
- ENC_ERR_EN defined:
  - An illegal kind (10–15) is still accepted and emits 32'h0000_0000 (NOP) at the next address.
  - err sets in the cycle after acceptance and is sticky until start/reset.
- ENC_ERR_EN undefined:
  - An illegal kind emits 32'h0000_0000 the same way.
  - err is constant 0 and has no flop.

## Test plan
- ADD rs=31 rt=0 rd=17, out_ready=1 → next cycle out_word=32'h03E0_8820, out_addr=BASE_ADDR.
- Back-to-back ADDI rs=1 rt=2 imm=16'hFFFF, then J target=26'h0000010 → 32'h2022_FFFF @0, then 32'h0800_0010 @4; no bubble.
- Stall: hold out_ready=0 for 3 cycles after LW rs=4 rt=5 imm=8 → in_ready=0, out_word=32'h8C85_0008 stable; first cycle out_ready=1 accepts a queued SW at addr 4.
- DEPTH=4: stream 5 bundles → full=1 after 4th transfer, 5th held (in_ready=0); pulse start → 5th accepted at addr BASE_ADDR.
- kind=12 with ENC_ERR_EN → word 0, err=1 next cycle and held; without ENC_ERR_EN → word 0, err=0.
- Assert reset while out_valid=1, out_ready=0 → next cycle out_valid=0, out_addr=BASE_ADDR, full=0.
